muldiv_unit: RTL and testbench

Iterative multiply/divide unit with its own HI/LO registers. It sits downstream of the register file and consumes the RD1/RD2 read data for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Its HI/LO outputs feed the writeback mux for MFHI/MFLO. `busy` is used by control to stall the pipeline.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit:
// operation codes, FSM states and the default operand width.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide with HI/LO registers; one step per
// clock, a final sign-fix cycle, and direct MTHI/MTLO writes when idle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic               sign_a;
    logic               sign_b;
    logic               is_div;
    logic               is_signed;

    // Shared adder/subtractor; the extra top bit is the borrow on subtract.
    function automatic logic [WIDTH+1:0] addsub(
        input logic [WIDTH:0] x,
        input logic [WIDTH:0] y,
        input logic           sub
    );
        addsub = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    endfunction

    logic               in_signed;
    logic               in_sa;
    logic               in_sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH+1:0]   mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH:0]   div_sh;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        in_signed = ~op[0];
        in_sa     = in_signed & a[WIDTH-1];
        in_sb     = in_signed & b[WIDTH-1];
        mag_a     = in_sa ? -a : a;
        mag_b     = in_sb ? -b : b;

        div_sh   = {acc, 1'b0};
        mul_sum  = addsub({1'b0, acc[2*WIDTH-1:WIDTH]},
                          acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}}, 1'b0);
        div_diff = addsub(div_sh[2*WIDTH:WIDTH], {1'b0, opnd}, 1'b1);

        if (is_div) begin
            // Restore on borrow: keep the shifted remainder, quotient bit 0.
            if (div_diff[WIDTH+1])
                acc_next = div_sh[2*WIDTH-1:0];
            else
                acc_next = {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
        end else begin
            acc_next = {mul_sum[WIDTH:0], acc[WIDTH-1:1]};
        end

        prod = (is_signed && (sign_a ^ sign_b)) ? -acc : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (is_signed && (sign_a ^ sign_b))
            quo = -acc[WIDTH-1:0];
        if (is_signed && sign_a)
            rem = -acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            a_raw     <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                sign_a    <= in_sa;
                                sign_b    <= in_sb;
                                is_signed <= in_signed;
                                is_div    <= op[1];
                                a_raw     <= a;
                                acc       <= op[1] ? {{WIDTH{1'b0}}, mag_a}
                                                   : {{WIDTH{1'b0}}, mag_b};
                                opnd      <= op[1] ? mag_b : mag_a;
                                cnt       <= '0;
                                busy      <= 1'b1;
                                state     <= S_RUN;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (!is_div) begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end else if (opnd == '0) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem;
                        lo <= quo;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus queues expected HI/LO results,
// a negedge monitor pops and compares them on every done pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    logic done_q = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (done) begin
            check("done_pulse", W'(done_q), '0);
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: got done=1, want no pending result");
            end else begin
                e = sb.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
            end
        end
        done_q <= done;
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: got busy=1 after 100 cycles, want busy=0", name);
    endtask

    task automatic run(input string name, input logic [2:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t t;
        t.name = name;
        t.hi   = eh;
        t.lo   = el;
        sb.push_back(t);
        issue(o, x, y);
        wait_idle(name);
    endtask

    initial begin
        int n;
        exp_t t;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        rst = 1'b0;

        // Latency: busy counted at each negedge until it drops.
        t.name = "multu_max";
        t.hi   = 32'hFFFF_FFFE;
        t.lo   = 32'h0000_0001;
        sb.push_back(t);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("busy_cycles", W'(n), W'(33));
        check("done_after_busy", W'(done), W'(1));

        run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7,
            32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("mult_zero", OP_MULT, 32'd0, 32'h8000_0000, 32'd0, 32'd0);
        run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'd0, 32'h8000_0000);

        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'h8000_0000);
        check("mthi_busy", W'(busy), '0);
        check("mthi_done", W'(done), '0);

        t.name = "divu_mtlo";
        t.hi   = 32'd1;
        t.lo   = 32'd3;
        sb.push_back(t);
        issue(OP_DIVU, 32'd7, 32'd2);
        repeat (5) @(negedge clk);
        issue(OP_MTLO, 32'h0000_DEAD, 32'd0);
        check("busy_mtlo_lo", lo, 32'h8000_0000);
        check("busy_mtlo_busy", W'(busy), W'(1));
        wait_idle("divu_mtlo");

        issue(3'b110, 32'hAAAA_AAAA, 32'h5555_5555);
        @(negedge clk);
        check("nop_hi", hi, 32'd1);
        check("nop_lo", lo, 32'd3);
        check("nop_busy", W'(busy), '0);
        check("nop_done", W'(done), '0);

        issue(OP_MULTU, 32'd5, 32'd6);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        check("abort_busy", W'(busy), '0);
        @(negedge clk);
        rst = 1'b0;
        run("multu_small", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);

        repeat (3) @(negedge clk);
        check("sb_empty", W'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
